mem_reader: RTL and testbench

MEM_READER -- requirements
Module: mem_reader

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_reader_fifo2.sv | 60 ++++++
 rtl/mem_reader.sv | 135 +++++++++++++
 tb/tb_mem_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the mem_reader block: width defaults and the
// controller state type.
package mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/mem_reader_fifo2.sv
// Two-entry output FIFO for mem_reader. The head word is always held in
// 'head', so rdata is a plain register output and stays stable until popped.
// The caller must not push while full unless it also pops in that cycle.
module mem_reader_fifo2
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign rdata  = head;
    assign full   = (count == 2'd2);
    assign empty  = (count == 2'd0);

    // Storage and occupancy update; the head shifts forward on every pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the two entries are reset too, because dataOut must read 0 after reset.
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= wdata;
                    else               tail <= wdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= wdata;
                    end else begin
                        head <= tail;
                        tail <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_reader.sv
// mem_reader: streams a burst of 'len' words from a 1-cycle-latency
// synchronous memory, starting at baseAddr, through a 2-entry FIFO with a
// valid/ready handshake. Reads are only issued when the FIFO is guaranteed
// room for the returning word.
// Optional build macro: MEM_READER_PARITY_EN adds dataOutPar (even parity).
module mem_reader
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [ADDR_W:0]   len,
    output logic              memRdEn,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memRdData,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataOutValid,
    input  logic              dataOutReady,
    output logic              busy,
    output logic              done
`ifdef MEM_READER_PARITY_EN
    ,
    output logic              dataOutPar
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   rd_left;
    logic [ADDR_W:0]   xfer_left;
    logic              rd_pending;

    logic              pop;
    logic              push;
    logic              credit;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;
    logic [2:0]        limit;

    assign pop          = dataOutValid && dataOutReady;
    assign dataOutValid = !fifo_empty;
    assign memAddr      = addr;

    // A word in flight lands in the FIFO at the end of the cycle after its
    // read strobe; a new read is allowed only if that still leaves room.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pending};
    assign limit     = 3'd2 + {2'b00, pop};
    assign credit    = (occupancy < limit);
    assign push      = rd_pending && (!fifo_full || pop);

`ifdef MEM_READER_PARITY_EN
    assign dataOutPar = ^dataOut;
`endif

    mem_reader_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (memRdData),
        .rdata (dataOut),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state and control outputs of the burst controller.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        state_nxt = state;
        memRdEn   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len == '0) ? FINISH : READ;
                end
            end
            READ: begin
                if (credit) begin
                    memRdEn = 1'b1;
                    if (rd_left == (ADDR_W+1)'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (xfer_left == (ADDR_W+1)'(1))) state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, burst capture, address and word counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state      <= IDLE;
            addr       <= '0;
            rd_left    <= '0;
            xfer_left  <= '0;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_pending <= memRdEn;
            if (state == IDLE) begin
                if (start) begin
                    addr      <= baseAddr;
                    rd_left   <= len;
                    xfer_left <= len;
                end
            end else begin
                if (memRdEn) begin
                    addr    <= addr + ADDR_W'(1);
                    rd_left <= rd_left - (ADDR_W+1)'(1);
                end
                if (pop) xfer_left <= xfer_left - (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader: a behavioural 1-cycle-latency memory
// preloaded with mem[i]=i, directed bursts, and a scoreboard monitor that
// checks read addresses and streamed words against hand-computed queues.
module tb_mem_reader;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] baseAddr;
    logic [AW:0]   len;
    logic          memRdEn;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memRdData = '0;
    logic [DW-1:0] dataOut;
    logic          dataOutValid;
    logic          dataOutReady = 1'b1;
    logic          busy;
    logic          done;
`ifdef MEM_READER_PARITY_EN
    logic          dataOutPar;
`endif

    mem_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .baseAddr     (baseAddr),
        .len          (len),
        .memRdEn      (memRdEn),
        .memAddr      (memAddr),
        .memRdData    (memRdData),
        .dataOut      (dataOut),
        .dataOutValid (dataOutValid),
        .dataOutReady (dataOutReady),
        .busy         (busy),
        .done         (done)
`ifdef MEM_READER_PARITY_EN
        ,
        .dataOutPar   (dataOutPar)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: 1-cycle read latency, mem[i] = i.
    logic [DW-1:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = DW'(i);
    always @(posedge clk) if (memRdEn) memRdData <= mem[memAddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver: mode 0 holds ready high, mode 1 plays 1,0,0,1,0,0,...
    int rdy_mode  = 0;
    int rdy_phase = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) begin
            dataOutReady = 1'b1;
        end else begin
            dataOutReady = ((rdy_phase % 3) == 0);
            rdy_phase++;
        end
    end

    // Scoreboard queues, filled by the stimulus.
    logic [DW-1:0] exp_q  [$];
    logic [AW-1:0] addr_q [$];

    int            issued     = 0;
    int            xfered     = 0;
    int            burst_xfer = 0;
    int            first_xcyc = 0;
    int            last_xcyc  = 0;
    int            done_cnt   = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    // Monitor: compares every read strobe and every transfer as it happens.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (memRdEn) begin
            issued++;
            if (addr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL extra_read: got addr %0d, expected no read", memAddr);
            end else begin
                check("mem_addr", 32'(memAddr), 32'(addr_q.pop_front()));
            end
        end
        if (dataOutValid && dataOutReady) begin
            xfered++;
            burst_xfer++;
            if (burst_xfer == 1) first_xcyc = cyc;
            last_xcyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL extra_word: got %0h, expected no transfer", dataOut);
            end else begin
                e = exp_q.pop_front();
                check("data_out", 32'(dataOut), 32'(e));
`ifdef MEM_READER_PARITY_EN
                check("data_par", 32'(dataOutPar), 32'(^e));
`endif
            end
        end
        if (memRdEn) check("outstanding_le2", 32'((issued - xfered) <= 2), 32'd1);
        if (stall_prev && dataOutValid) check("stall_stable", 32'(dataOut), 32'(stall_data));
        stall_prev = dataOutValid && !dataOutReady;
        stall_data = dataOut;
        if (done) done_cnt++;
    end

    // Issue one burst and queue its hand-computed addresses and words.
    task automatic run_burst(input logic [AW-1:0] base, input int length);
        logic [AW-1:0] a;
        a = base;
        for (int i = 0; i < length; i++) begin
            addr_q.push_back(a);
            exp_q.push_back(DW'(a));
            a = a + AW'(1);
        end
        burst_xfer = 0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        baseAddr = base;
        len      = (AW+1)'(length);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (length > 0) begin
            check("first_rd_en", 32'(memRdEn), 32'd1);
            check("first_rd_addr", 32'(memAddr), 32'(base));
        end
    endtask

    // Wait (bounded) for the done pulse, then check the burst closed cleanly.
    task automatic wait_done(input string name, output int done_cyc);
        bit seen;
        seen     = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done, expected done within 300 cycles", name);
        end else begin
            check({name, "_busy_at_done"}, 32'(busy), 32'd1);
            check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
            check({name, "_reads_left"}, 32'(addr_q.size()), 32'd0);
            @(posedge clk);
            #1;
            check({name, "_done_one_cycle"}, 32'(done), 32'd0);
            check({name, "_idle_after"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int dc;
        int d0;
        bit hit;
        rst      = 1'b1;
        start    = 1'b0;
        baseAddr = '0;
        len      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", 32'(memRdEn), 32'd0);
        check("rst_addr", 32'(memAddr), 32'd0);
        check("rst_data", 32'(dataOut), 32'd0);
        check("rst_valid", 32'(dataOutValid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef MEM_READER_PARITY_EN
        check("rst_par", 32'(dataOutPar), 32'd0);
`endif
        rst = 1'b0;

        // Base 0, length 10, ready held: ten words back-to-back, one done.
        rdy_mode = 0;
        d0 = done_cnt;
        run_burst(6'd0, 10);
        wait_done("b10", dc);
        check("b10_back_to_back", 32'(last_xcyc - first_xcyc), 32'd9);
        check("b10_done_timing", 32'(dc), 32'(last_xcyc + 1));
        check("b10_done_count", 32'(done_cnt - d0), 32'd1);

        // Address wrap: 62, 63, 0, 1.
        run_burst(6'd62, 4);
        wait_done("wrap", dc);

        // Ready toggling 1,0,0: no loss, no duplicates, stable while stalled.
        rdy_mode  = 1;
        rdy_phase = 0;
        run_burst(6'd10, 5);
        wait_done("stall", dc);
        rdy_mode = 0;

        // Zero-length burst: FINISH directly, no reads.
        d0 = done_cnt;
        run_burst(6'd5, 0);
        check("len0_busy", 32'(busy), 32'd1);
        check("len0_done", 32'(done), 32'd1);
        check("len0_rd_en", 32'(memRdEn), 32'd0);
        @(posedge clk);
        #1;
        check("len0_busy_drop", 32'(busy), 32'd0);
        check("len0_done_drop", 32'(done), 32'd0);
        check("len0_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset after 3 of 8 words: abort, no done, stale data discarded.
        run_burst(6'd30, 8);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (burst_xfer >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL abort_wait: got %0d transfers, expected 3 within 100 cycles", burst_xfer);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rd_en", 32'(memRdEn), 32'd0);
        check("abort_addr", 32'(memAddr), 32'd0);
        check("abort_data", 32'(dataOut), 32'd0);
        check("abort_valid", 32'(dataOutValid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        addr_q.delete();
        issued = 0;
        xfered = 0;
        rst    = 1'b0;
        d0     = done_cnt;
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_no_stale", 32'(dataOutValid), 32'd0);
        run_burst(6'd20, 2);
        wait_done("post_abort", dc);

        // Words 3..7 include 0x03 (parity 0) and 0x07 (parity 1).
        run_burst(6'd3, 5);
        wait_done("par", dc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
